quad_encoder_array: RTL and testbench

Parametrised multi-channel rotary/quadrature encoder front end for the Basys 3 PMOD encoder path. It replaces the single-channel debounce + encoder pair with N independent channels. Each channel has:
- a synchronised, debounced A/B/BTN input path;
- selectable x1/x2/x4 decoding;
- a wrap or saturate position counter;
- direction, step and error flags.

Counter outputs feed the LED/display control logic directly.

---
 rtl/quad_encoder_array.sv | 151 +++++++++++++++
 tb/tb_quad_encoder_array.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature encoder front end: per-channel synchroniser, debounce,
// x1/x2/x4 decoding, wrapping or saturating position counter, and button clear.
module quad_encoder_array #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 8,
  parameter int DB_CYCLES = 100000,
  parameter int SATURATE  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       A,
  input  logic [NUM_CH-1:0]       B,
  input  logic [NUM_CH-1:0]       BTN,
  input  logic [1:0]              mode,
  input  logic                    clr,
  output logic                    ready,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       dir,
  output logic [NUM_CH-1:0]       step,
  output logic [NUM_CH-1:0]       btn_press,
  output logic [NUM_CH-1:0]       err
);

  localparam int NS   = 3 * NUM_CH;
  localparam int DB_W = $clog2(DB_CYCLES);
  localparam int ST_W = $clog2(DB_CYCLES + 3);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(DB_CYCLES + 2);
  localparam bit SAT = (SATURATE != 0);

  // Flattened input bus: A at [ch], B at [NUM_CH+ch], BTN at [2*NUM_CH+ch]
  logic [NS-1:0]   raw, sync1, sync2, db;
  logic [ST_W-1:0] settle_cnt;

  assign raw = {BTN, B, A};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar g = 0; g < NS; g++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            lvl;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
          lvl <= 1'b0;
        end else if (sync2[g] == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign db[g] = lvl;
    end
  endgenerate

  // Settle window lets debounced levels reach the idle input state before decoding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      ready      <= 1'b0;
    end else if (!ready) begin
      if (settle_cnt == ST_LAST) ready <= 1'b1;
      else                       settle_cnt <= settle_cnt + 1'b1;
    end
  end

  generate
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [1:0]       cur, prev;
      logic             btn_db, btn_prev, btn_rise;
      logic             mv_cw, mv_ccw, illegal, pass, counted, blocked;
      logic [CNT_W-1:0] cnt;
      logic             dir_r, step_r, press_r, err_r;

      assign cur      = {db[ch], db[NUM_CH+ch]};
      assign btn_db   = db[2*NUM_CH+ch];
      assign btn_rise = btn_db & ~btn_prev;
      assign illegal  = ((prev ^ cur) == 2'b11);
      assign pass     = mode[1] | (cur == 2'b00) | (mode[0] & (cur == 2'b11));
      assign counted  = (mv_cw | mv_ccw) & pass;
      assign blocked  = SAT && ((mv_cw && (&cnt)) || (mv_ccw && !(|cnt)));

      always_comb begin
        mv_cw  = 1'b0;
        mv_ccw = 1'b0;
        case ({prev, cur})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: mv_cw  = 1'b1;
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: mv_ccw = 1'b1;
          default: ;
        endcase
      end

      // Priority: clr, then button clear, then step; prev always follows cur
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev     <= 2'b00;
          btn_prev <= 1'b0;
          cnt      <= '0;
          dir_r    <= 1'b0;
          step_r   <= 1'b0;
          press_r  <= 1'b0;
          err_r    <= 1'b0;
        end else begin
          step_r   <= 1'b0;
          press_r  <= 1'b0;
          prev     <= cur;
          btn_prev <= btn_db;
          if (ready) begin
            if (clr) begin
              cnt   <= '0;
              err_r <= 1'b0;
            end else begin
              if (illegal) err_r <= 1'b1;
              if (btn_rise) begin
                cnt     <= '0;
                press_r <= 1'b1;
              end else if (counted) begin
                dir_r <= mv_cw;
                if (!blocked) begin
                  cnt    <= mv_cw ? cnt + 1'b1 : cnt - 1'b1;
                  step_r <= 1'b1;
                end
              end
            end
          end
        end
      end

      assign count[ch*CNT_W +: CNT_W] = cnt;
      assign dir[ch]       = dir_r;
      assign step[ch]      = step_r;
      assign btn_press[ch] = press_r;
      assign err[ch]       = err_r;
    end
  endgenerate

endmodule

// File: tb/tb_quad_encoder_array.sv
// Bench for quad_encoder_array: a wrapping and a saturating instance share stimulus
// and are compared against a position-arithmetic reference model.
module tb_quad_encoder_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] A, B, BTN;
  logic [1:0] mode;
  logic       clr;

  logic       ready_w, ready_s;
  logic [7:0] count_w, count_s;
  logic [1:0] dir_w, dir_s, step_w, step_s, press_w, press_s, err_w, err_s;

  always #5 clk = ~clk;

  quad_encoder_array #(.NUM_CH(2), .CNT_W(4), .DB_CYCLES(4), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .BTN(BTN), .mode(mode), .clr(clr),
    .ready(ready_w), .count(count_w), .dir(dir_w), .step(step_w),
    .btn_press(press_w), .err(err_w)
  );

  quad_encoder_array #(.NUM_CH(2), .CNT_W(4), .DB_CYCLES(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .BTN(BTN), .mode(mode), .clr(clr),
    .ready(ready_s), .count(count_s), .dir(dir_s), .step(step_s),
    .btn_press(press_s), .err(err_s)
  );

  int n_pass = 0;
  int n_total = 0;

  // Pulse tallies from the DUTs
  int step_seen[2], step_seen_s[2], press_seen[2];

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (step_w[c])  step_seen[c]++;
      if (step_s[c])  step_seen_s[c]++;
      if (press_w[c]) press_seen[c]++;
    end
  end

  // Reference model: encoder position on the 4-state cycle, counts as integers
  int m_ab[2], m_cnt[2], m_cnt_s[2], m_dir[2], m_dir_s[2], m_err[2];
  int e_step[2], e_step_s[2], e_press[2];

  function automatic int pos_of(int ab);
    case (ab)
      0: return 0;
      1: return 1;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int ab_of(int p);
    case (p % 4)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_move(int ch, int nab, int md, bit suppress);
    int d;
    bit cw;
    d = (pos_of(nab) - pos_of(m_ab[ch]) + 4) % 4;
    m_ab[ch] = nab;
    if (d == 0) return;
    if (d == 2) begin
      m_err[ch] = 1;
      return;
    end
    cw = (d == 1);
    if (!(md >= 2 || nab == 0 || (md == 1 && nab == 3))) return;
    if (suppress) return;
    m_dir[ch] = cw;
    m_cnt[ch] = (m_cnt[ch] + (cw ? 1 : 15)) % 16;
    e_step[ch]++;
    m_dir_s[ch] = cw;
    if (!((cw && m_cnt_s[ch] == 15) || (!cw && m_cnt_s[ch] == 0))) begin
      m_cnt_s[ch] = m_cnt_s[ch] + (cw ? 1 : -1);
      e_step_s[ch]++;
    end
  endtask

  task automatic model_btn(int ch);
    m_cnt[ch] = 0;
    m_cnt_s[ch] = 0;
    e_press[ch]++;
  endtask

  task automatic model_clr();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0; m_cnt_s[c] = 0; m_err[c] = 0;
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ab(int ch, int ab);
    A[ch] = ab[1];
    B[ch] = ab[0];
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    model_clr();
  endtask

  task automatic test_reset();
    int early_hi = 0;
    A = 2'b11; B = 2'b11; BTN = 2'b00; mode = 2'b10; clr = 1'b0;
    rst_n = 1'b0;
    tick(3);
    n_total++;
    if ({ready_w, ready_s, count_w, count_s, err_w, err_s} !== '0)
      $display("FAIL reset_values: ready=%b/%b count=%h/%h err=%b/%b expected all zero",
               ready_w, ready_s, count_w, count_s, err_w, err_s);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      if (ready_w !== 1'b0 || ready_s !== 1'b0) early_hi++;
    end
    n_total++;
    if (early_hi != 0) $display("FAIL settle_ready_low: ready high in %0d of 6 settle cycles, expected 0", early_hi);
    else n_pass++;
    tick(1);
    n_total++;
    if (ready_w !== 1'b1 || ready_s !== 1'b1) $display("FAIL ready_rise: got %b/%b expected 1/1", ready_w, ready_s);
    else n_pass++;
    tick(10);
    for (int c = 0; c < 2; c++) m_ab[c] = 3;
    n_total++;
    if (count_w !== 8'h00 || err_w !== 2'b00 || step_seen[0] + step_seen[1] != 0 || err_s !== 2'b00)
      $display("FAIL idle_high_settle: count=%h err=%b/%b steps=%0d expected 00/00/00/0",
               count_w, err_w, err_s, step_seen[0] + step_seen[1]);
    else n_pass++;
  endtask

  task automatic test_home();
    mode = 2'b10;
    set_ab(0, 2); model_move(0, 2, 2, 1'b0);
    set_ab(1, 1); model_move(1, 1, 2, 1'b0);
    tick(10);
    set_ab(0, 0); model_move(0, 0, 2, 1'b0);
    set_ab(1, 0); model_move(1, 0, 2, 1'b0);
    tick(10);
    n_total++;
    if (count_w !== {4'(m_cnt[1]), 4'(m_cnt[0])} || count_s !== {4'(m_cnt_s[1]), 4'(m_cnt_s[0])})
      $display("FAIL home_counts: got %h/%h expected %h%h/%h%h", count_w, count_s,
               4'(m_cnt[1]), 4'(m_cnt[0]), 4'(m_cnt_s[1]), 4'(m_cnt_s[0]));
    else n_pass++;
    pulse_clr();
    n_total++;
    if (count_w !== 8'h00 || count_s !== 8'h00)
      $display("FAIL clr_next_cycle: got %h/%h expected 00/00", count_w, count_s);
    else n_pass++;
    tick(2);
  endtask

  task automatic test_x4();
    int fwd[4] = '{1, 3, 2, 0};
    int rev[4] = '{2, 3, 1, 0};
    bit early, on, late;
    mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      set_ab(0, fwd[i]); model_move(0, fwd[i], 2, 1'b0);
      tick(6); early = step_w[0];
      tick(1); on = step_w[0];
      tick(1); late = step_w[0];
      n_total++;
      if ({early, on, late} !== 3'b010)
        $display("FAIL x4_step_timing[%0d]: step at edges 6/7/8 = %b expected 010", i, {early, on, late});
      else n_pass++;
      tick(2);
    end
    n_total++;
    if (count_w[3:0] !== 4'(m_cnt[0]) || dir_w[0] !== 1'(m_dir[0]) || step_seen[0] != e_step[0])
      $display("FAIL x4_cw: count=%0d dir=%b steps=%0d expected %0d/%0d/%0d",
               count_w[3:0], dir_w[0], step_seen[0], m_cnt[0], m_dir[0], e_step[0]);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      set_ab(0, rev[i]); model_move(0, rev[i], 2, 1'b0);
      tick(10);
    end
    n_total++;
    if (count_w[3:0] !== 4'(m_cnt[0]) || dir_w[0] !== 1'(m_dir[0]) || step_seen[0] != e_step[0])
      $display("FAIL x4_ccw: count=%0d dir=%b steps=%0d expected %0d/%0d/%0d",
               count_w[3:0], dir_w[0], step_seen[0], m_cnt[0], m_dir[0], e_step[0]);
    else n_pass++;
  endtask

  task automatic test_modes_wrap();
    int rev[4] = '{2, 3, 1, 0};
    for (int md = 0; md < 2; md++) begin
      mode = 2'(md);
      for (int cyc = 0; cyc < 5; cyc++)
        for (int i = 0; i < 4; i++) begin
          set_ab(1, rev[i]); model_move(1, rev[i], md, 1'b0);
          tick(10);
        end
      n_total++;
      if (count_w[7:4] !== 4'(m_cnt[1]) || step_seen[1] != e_step[1])
        $display("FAIL mode%0d_wrap: count=%0d steps=%0d expected %0d/%0d",
                 md, count_w[7:4], step_seen[1], m_cnt[1], e_step[1]);
      else n_pass++;
      n_total++;
      if (count_s[7:4] !== 4'(m_cnt_s[1]) || step_seen_s[1] != e_step_s[1] || dir_s[1] !== 1'(m_dir_s[1]))
        $display("FAIL mode%0d_sat: count=%0d steps=%0d dir=%b expected %0d/%0d/%0d",
                 md, count_s[7:4], step_seen_s[1], dir_s[1], m_cnt_s[1], e_step_s[1], m_dir_s[1]);
      else n_pass++;
      pulse_clr();
      tick(2);
    end
  endtask

  task automatic test_debounce();
    int steps_before;
    mode = 2'b10;
    steps_before = step_seen[0];
    for (int i = 0; i < 3; i++) begin
      A[0] = 1'b1; tick(3);
      A[0] = 1'b0; tick(6);
    end
    n_total++;
    if (step_seen[0] != steps_before || count_w[3:0] !== 4'(m_cnt[0]))
      $display("FAIL glitch_reject: steps=%0d count=%0d expected %0d/%0d",
               step_seen[0], count_w[3:0], steps_before, m_cnt[0]);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      A[0] = 1'b1; tick(2);
      A[0] = 1'b0; tick(2);
    end
    A[0] = 1'b1; model_move(0, 2, 2, 1'b0);
    tick(12);
    n_total++;
    if (step_seen[0] != steps_before + 1 || count_w[3:0] !== 4'(m_cnt[0]))
      $display("FAIL chatter_one_step: steps=%0d count=%0d expected %0d/%0d",
               step_seen[0], count_w[3:0], steps_before + 1, m_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_illegal();
    int nab;
    nab = m_ab[0] ^ 3;
    set_ab(0, nab); model_move(0, nab, 2, 1'b0);
    tick(10);
    n_total++;
    if (err_w !== 2'b01 || err_s !== 2'b01 || count_w[3:0] !== 4'(m_cnt[0]))
      $display("FAIL illegal_err: err=%b/%b count=%0d expected 01/01/%0d", err_w, err_s, count_w[3:0], m_cnt[0]);
    else n_pass++;
    pulse_clr();
    n_total++;
    if (err_w !== 2'b00 || err_s !== 2'b00 || count_w !== 8'h00)
      $display("FAIL illegal_clr: err=%b/%b count=%h expected 00/00/00", err_w, err_s, count_w);
    else n_pass++;
    tick(2);
  endtask

  task automatic test_random();
    int r, nab, bc;
    for (int it = 0; it < 30; it++) begin
      mode = 2'($urandom_range(0, 3));
      for (int c = 0; c < 2; c++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      nab = m_ab[c] ^ 3;
        else if (r <= 4) nab = ab_of(pos_of(m_ab[c]) + 1);
        else if (r <= 8) nab = ab_of(pos_of(m_ab[c]) + 3);
        else             nab = m_ab[c];
        set_ab(c, nab); model_move(c, nab, int'(mode), 1'b0);
      end
      tick(10);
      if ($urandom_range(0, 5) == 0) begin
        bc = $urandom_range(0, 1);
        BTN[bc] = 1'b1; model_btn(bc);
        tick(10);
        BTN[bc] = 1'b0;
        tick(10);
      end
      if ($urandom_range(0, 7) == 0) begin
        pulse_clr();
        tick(2);
      end
      for (int c = 0; c < 2; c++) begin
        n_total++;
        if (count_w[c*4 +: 4] !== 4'(m_cnt[c]) || count_s[c*4 +: 4] !== 4'(m_cnt_s[c]))
          $display("FAIL rand_count it%0d ch%0d: got %0d/%0d expected %0d/%0d",
                   it, c, count_w[c*4 +: 4], count_s[c*4 +: 4], m_cnt[c], m_cnt_s[c]);
        else n_pass++;
        n_total++;
        if (dir_w[c] !== 1'(m_dir[c]) || dir_s[c] !== 1'(m_dir_s[c]) || err_w[c] !== 1'(m_err[c]))
          $display("FAIL rand_flags it%0d ch%0d: dir=%b/%b err=%b expected %0d/%0d/%0d",
                   it, c, dir_w[c], dir_s[c], err_w[c], m_dir[c], m_dir_s[c], m_err[c]);
        else n_pass++;
        n_total++;
        if (step_seen[c] != e_step[c] || step_seen_s[c] != e_step_s[c] || press_seen[c] != e_press[c])
          $display("FAIL rand_pulses it%0d ch%0d: step=%0d/%0d press=%0d expected %0d/%0d/%0d",
                   it, c, step_seen[c], step_seen_s[c], press_seen[c], e_step[c], e_step_s[c], e_press[c]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int early_hi = 0;
    int s0, s1;
    mode = 2'b10;
    for (int c = 0; c < 2; c++) begin
      nab_cw(c);
    end
    tick(10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (count_w !== 8'h00 || ready_w !== 1'b0 || dir_w !== 2'b00 || count_s !== 8'h00)
      $display("FAIL async_reset: count=%h/%h ready=%b dir=%b expected 00/00/0/00", count_w, count_s, ready_w, dir_w);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0; m_cnt_s[c] = 0; m_dir[c] = 0; m_dir_s[c] = 0; m_err[c] = 0;
    end
    tick(2);
    rst_n = 1'b1;
    s0 = step_seen[0]; s1 = step_seen[1];
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (ready_w !== 1'b0) early_hi++;
    end
    tick(1);
    n_total++;
    if (early_hi != 0 || ready_w !== 1'b1)
      $display("FAIL resettle_ready: early highs=%0d ready=%b expected 0/1", early_hi, ready_w);
    else n_pass++;
    tick(5);
    n_total++;
    if (count_w !== 8'h00 || err_w !== 2'b00 || step_seen[0] != s0 || step_seen[1] != s1)
      $display("FAIL resettle_quiet: count=%h err=%b steps=%0d,%0d expected 00/00/%0d,%0d",
               count_w, err_w, step_seen[0], step_seen[1], s0, s1);
    else n_pass++;
  endtask

  task automatic nab_cw(int c);
    int nab;
    nab = ab_of(pos_of(m_ab[c]) + 1);
    set_ab(c, nab); model_move(c, nab, int'(mode), 1'b0);
  endtask

  task automatic test_priority();
    int s0, nab;
    mode = 2'b10;
    nab_cw(0); tick(10);
    nab_cw(0); tick(10);
    s0 = step_seen[0];
    nab = ab_of(pos_of(m_ab[0]) + 1);
    BTN[0] = 1'b1; set_ab(0, nab);
    model_move(0, nab, 2, 1'b1); model_btn(0);
    tick(10);
    n_total++;
    if (count_w[3:0] !== 4'd0 || press_seen[0] != e_press[0] || step_seen[0] != s0 || dir_w[0] !== 1'(m_dir[0]))
      $display("FAIL btn_vs_step: count=%0d press=%0d steps=%0d dir=%b expected 0/%0d/%0d/%0d",
               count_w[3:0], press_seen[0], step_seen[0], dir_w[0], e_press[0], s0, m_dir[0]);
    else n_pass++;
    BTN[0] = 1'b0; tick(10);
    nab = m_ab[0] ^ 3;
    set_ab(0, nab); model_move(0, nab, 2, 1'b0); tick(10);
    nab_cw(0); tick(10);
    nab_cw(1); tick(10);
    s0 = step_seen[0];
    nab = ab_of(pos_of(m_ab[0]) + 1);
    BTN[0] = 1'b1; set_ab(0, nab);
    model_move(0, nab, 2, 1'b1);
    tick(6);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    model_clr();
    tick(5);
    n_total++;
    if (count_w !== 8'h00 || count_s !== 8'h00 || err_w !== 2'b00 || step_seen[0] != s0)
      $display("FAIL clr_vs_btn_step: count=%h/%h err=%b steps=%0d expected 00/00/00/%0d",
               count_w, count_s, err_w, step_seen[0], s0);
    else n_pass++;
    BTN[0] = 1'b0;
    tick(10);
  endtask

  initial begin
    A = 2'b00; B = 2'b00; BTN = 2'b00; mode = 2'b10; clr = 1'b0; rst_n = 1'b0;
    test_reset();
    test_home();
    test_x4();
    test_modes_wrap();
    test_debounce();
    test_illegal();
    test_random();
    test_reset_mid();
    test_priority();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
